bufgce_div_seq: RTL and testbench
=================================

Name: bufgce_div_seq

Overview:
- Sequencer that sits directly upstream of a BUFGCE_DIV instance and drives its CE and CLR pins.
- Starts and stops the divided clock with a fixed, glitch-safe ordering: clear, then enable, then report ready; on stop, disable, then drain, then clear.
- Produces DIV_STB, a source-domain strobe marking each divided-clock period, so fabric logic on the undivided clock knows the divided phase.
- Runs on the same clock that feeds the buffer's I input.

Parameters:
- DIVIDE, 4, divide ratio of the downstream buffer; legal 1..8, elaboration error otherwise.
- CLR_CYCLES, 2, CLK cycles CLR is held high after a start request; legal 1..15.
- CE_LAT, 3, CLK cycles allowed for CE to propagate through the buffer's CE synchroniser; legal 1..15 (3 for HARDSYNC, 1 for SYNC).

Ports:
- CLK  in  1  clock; same net as the buffer's I.
- RST_N  in  1  asynchronous active-low reset.
- REQ_ON  in  1  start request, level-sampled on rising CLK.
- REQ_OFF  in  1  stop request, level-sampled on rising CLK.
- CE  out  1  to buffer CE.
- CLR  out  1  to buffer CLR, active high.
- READY  out  1  divided clock running and phase-tracked.
- BUSY  out  1  sequence in progress (CLEAR, ARM or DRAIN).
- DIV_STB  out  1  one-CLK pulse at the start of each divided period.

Behaviour:
- All outputs are registered and decoded from state; no combinational input-to-output path.
- Reset (RST_N low, asynchronous): state OFF, CLR=1, CE=0, READY=0, BUSY=0, DIV_STB=0, counters 0.
- State OFF: CLR=1, CE=0.
  - REQ_ON=1 and REQ_OFF=0 -> CLEAR.
  - REQ_ON and REQ_OFF both high -> stay OFF (stop wins).
- State CLEAR: CLR=1, CE=0, BUSY=1; lasts exactly CLR_CYCLES cycles, then -> ARM.
- State ARM: CLR=0, CE=1, BUSY=1; lasts exactly CE_LAT cycles, then -> RUN.
- Abort: REQ_OFF=1 in CLEAR or ARM -> OFF on the next edge. CE drops and CLR rises in the same cycle; no DRAIN.
- State RUN: CLR=0, CE=1, READY=1, BUSY=0.
  - 3-bit phase counter starts at 0 on entry, increments each cycle, wraps DIVIDE-1 -> 0.
  - DIV_STB=1 whenever phase==0 in RUN.
  - DIVIDE=1: DIV_STB high every RUN cycle.
  - REQ_ON in RUN is ignored. REQ_OFF=1 -> DRAIN.
- State DRAIN: CE=0, CLR=0, READY=0, BUSY=1, DIV_STB=0.
  - Lasts exactly CE_LAT+DIVIDE cycles so the last divided period completes and the output parks low; then -> OFF (CLR=1).
  - REQ_ON and REQ_OFF are ignored; a new start requires REQ_ON sampled in OFF.
- Counters: one 5-bit shared duration counter (reloaded on each state entry, holds CE_LAT+DIVIDE ≤ 23) plus the 3-bit phase counter. No overflow is possible at legal parameter values.
- Reset asserted mid-sequence returns to reset values immediately, regardless of state.
- Timeline, defaults: REQ_ON sampled at edge 0 -> CLEAR in cycles 1-2, ARM in cycles 3-5, RUN from cycle 6, DIV_STB at cycles 6, 10, 14, …

Test Plan:
- Reset then idle 10 cycles -> CLR=1, CE=0, READY=0, BUSY=0, DIV_STB=0 throughout.
- Defaults, REQ_ON pulse at edge 0 -> CLR high cycles 1-2; CE rises at cycle 3; READY rises at cycle 6; DIV_STB at 6, 10, 14; BUSY high in cycles 1-5 only.
- RUN, REQ_OFF at edge in cycle 20 -> CE=0 and READY=0 from cycle 21; BUSY high in cycles 21-27 (7 cycles); CLR=1 and OFF at cycle 28; no DIV_STB after cycle 20.
- REQ_OFF during ARM (cycle 4) -> cycle 5 shows CE=0, CLR=1, BUSY=0; READY never rises. REQ_ON and REQ_OFF together in OFF -> no state change.
- DIVIDE=1, CE_LAT=1, CLR_CYCLES=1 -> REQ_ON at edge 0 gives READY at cycle 3 and DIV_STB continuously high from cycle 3; REQ_OFF then gives exactly 2 DRAIN cycles.
- RST_N pulled low mid-DRAIN, asynchronously between edges -> outputs return to reset values without waiting for a CLK edge. After release, REQ_ON restarts the full CLEAR/ARM sequence.

Source files
------------

// File: rtl/bufgce_div_seq.sv
// rtl/bufgce_div_seq.sv - CE/CLR sequencer and divided-phase strobe for a BUFGCE_DIV
// Start: clear, enable, ready. Stop: disable, drain, clear. Every output is a registered state decode.
module bufgce_div_seq #(
  parameter int DIVIDE     = 4,
  parameter int CLR_CYCLES = 2,
  parameter int CE_LAT     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_on,
  input  logic req_off,
  output logic ce,
  output logic clr,
  output logic ready,
  output logic busy,
  output logic div_stb
);

  generate
    if (DIVIDE < 1 || DIVIDE > 8) begin : g_bad_divide
      $error("bufgce_div_seq: DIVIDE must be 1..8");
    end
    if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
      $error("bufgce_div_seq: CLR_CYCLES must be 1..15");
    end
    if (CE_LAT < 1 || CE_LAT > 15) begin : g_bad_ce_lat
      $error("bufgce_div_seq: CE_LAT must be 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_OFF,
    S_CLEAR,
    S_ARM,
    S_RUN,
    S_DRAIN
  } state_t;

  // Duration counter is loaded with (length - 1) on entry; the state exits when it reaches zero.
  localparam logic [4:0] CLR_LOAD   = 5'(CLR_CYCLES - 1);
  localparam logic [4:0] ARM_LOAD   = 5'(CE_LAT - 1);
  localparam logic [4:0] DRAIN_LOAD = 5'(CE_LAT + DIVIDE - 1);
  localparam logic [2:0] PH_LAST    = 3'(DIVIDE - 1);

  state_t     state;
  logic [4:0] cnt;
  logic [2:0] phase;
  logic [2:0] phase_next;

  always_comb begin
    phase_next = 3'd0;
    if (phase != PH_LAST) begin
      phase_next = phase + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OFF;
      cnt     <= 5'd0;
      phase   <= 3'd0;
      clr     <= 1'b1;
      ce      <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      div_stb <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          if (req_on && !req_off) begin
            state <= S_CLEAR;
            cnt   <= CLR_LOAD;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (req_off) begin
            state <= S_OFF;
            busy  <= 1'b0;
          end else if (cnt == 5'd0) begin
            state <= S_ARM;
            cnt   <= ARM_LOAD;
            clr   <= 1'b0;
            ce    <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_ARM: begin
          // Abort drops CE and raises CLR together; the divider never produced an edge.
          if (req_off) begin
            state <= S_OFF;
            clr   <= 1'b1;
            ce    <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == 5'd0) begin
            state   <= S_RUN;
            phase   <= 3'd0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            div_stb <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_RUN: begin
          if (req_off) begin
            state   <= S_DRAIN;
            cnt     <= DRAIN_LOAD;
            ce      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            div_stb <= 1'b0;
          end else begin
            phase   <= phase_next;
            div_stb <= (phase_next == 3'd0);
          end
        end
        S_DRAIN: begin
          // Wait out the CE synchroniser plus one full divided period so the output parks low.
          if (cnt == 5'd0) begin
            state <= S_OFF;
            clr   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          state   <= S_OFF;
          cnt     <= 5'd0;
          phase   <= 3'd0;
          clr     <= 1'b1;
          ce      <= 1'b0;
          ready   <= 1'b0;
          busy    <= 1'b0;
          div_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bufgce_div_seq.sv
// tb/tb_bufgce_div_seq.sv - scoreboard bench for bufgce_div_seq (default and minimal configurations)
module tb_bufgce_div_seq;

  // Output vector order: {clr, ce, ready, busy, div_stb}
  localparam logic [4:0] E_OFF   = 5'b10000;
  localparam logic [4:0] E_CLEAR = 5'b10010;
  localparam logic [4:0] E_ARM   = 5'b01010;
  localparam logic [4:0] E_RUN   = 5'b01100;
  localparam logic [4:0] E_STB   = 5'b01101;
  localparam logic [4:0] E_DRAIN = 5'b00010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_on = 1'b0, a_off = 1'b0, b_on = 1'b0, b_off = 1'b0;
  logic a_ce, a_clr, a_ready, a_busy, a_stb;
  logic b_ce, b_clr, b_ready, b_busy, b_stb;
  logic [4:0] a_out, b_out;
  logic [4:0] exp_q[$];
  int total = 0;
  int bad = 0;

  assign a_out = {a_clr, a_ce, a_ready, a_busy, a_stb};
  assign b_out = {b_clr, b_ce, b_ready, b_busy, b_stb};

  always #5 clk = ~clk;

  bufgce_div_seq dut_a (
    .clk(clk), .rst_n(rst_n), .req_on(a_on), .req_off(a_off),
    .ce(a_ce), .clr(a_clr), .ready(a_ready), .busy(a_busy), .div_stb(a_stb)
  );

  bufgce_div_seq #(.DIVIDE(1), .CLR_CYCLES(1), .CE_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_on(b_on), .req_off(b_off),
    .ce(b_ce), .clr(b_clr), .ready(b_ready), .busy(b_busy), .div_stb(b_stb)
  );

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got {clr,ce,ready,busy,stb}=%b want %b", tag, got, want);
    end
  endtask

  // Drive one cycle of requests, push the expectation, and compare after the edge.
  task automatic cyc(input bit sel, input logic on, input logic off,
                     input logic [4:0] want, input string tag);
    logic [4:0] e;
    if (sel) begin b_on = on; b_off = off; end
    else begin a_on = on; a_off = off; end
    exp_q.push_back(want);
    @(posedge clk);
    @(negedge clk);
    a_on = 1'b0; a_off = 1'b0; b_on = 1'b0; b_off = 1'b0;
    e = exp_q.pop_front();
    chk(tag, sel ? b_out : a_out, e);
  endtask

  // Default-config start timeline: cycle k follows the edge that sampled req_on at k=1.
  function automatic logic [4:0] start_exp(input int k);
    if (k <= 2) return E_CLEAR;
    if (k <= 5) return E_ARM;
    return (((k - 6) % 4) == 0) ? E_STB : E_RUN;
  endfunction

  initial begin
    logic [4:0] e;
    repeat (3) cyc(0, 1'b1, 1'b0, E_OFF, "held reset a");
    cyc(1, 1'b1, 1'b0, E_OFF, "held reset b");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(0, 1'b0, 1'b0, E_OFF, $sformatf("idle c%0d", k));
    cyc(1, 1'b0, 1'b0, E_OFF, "idle b");

    // Start, run (req_on in RUN ignored), stop at edge 20, drain 21-27 (req_on ignored), off at 28.
    for (int k = 1; k <= 20; k++)
      cyc(0, (k == 1 || k == 12), 1'b0, start_exp(k), $sformatf("start c%0d", k));
    for (int k = 21; k <= 27; k++)
      cyc(0, (k == 23), (k == 21), E_DRAIN, $sformatf("drain c%0d", k));
    cyc(0, 1'b0, 1'b0, E_OFF, "off c28");
    cyc(0, 1'b0, 1'b0, E_OFF, "off c29");

    // Abort during ARM: req_off sampled at the edge ending cycle 4.
    for (int k = 1; k <= 4; k++)
      cyc(0, (k == 1), 1'b0, start_exp(k), $sformatf("arm c%0d", k));
    cyc(0, 1'b0, 1'b1, E_OFF, "arm abort c5");
    for (int k = 6; k <= 9; k++) cyc(0, 1'b0, 1'b0, E_OFF, $sformatf("post abort c%0d", k));

    // Abort during CLEAR.
    cyc(0, 1'b1, 1'b0, E_CLEAR, "clr c1");
    cyc(0, 1'b0, 1'b1, E_OFF, "clr abort c2");
    cyc(0, 1'b0, 1'b0, E_OFF, "clr abort c3");

    // Both requests in OFF: stop wins.
    cyc(0, 1'b1, 1'b1, E_OFF, "both c1");
    for (int k = 2; k <= 4; k++) cyc(0, 1'b0, 1'b0, E_OFF, $sformatf("both c%0d", k));

    // Minimal config: ready at cycle 3, strobe every RUN cycle, two drain cycles.
    cyc(1, 1'b1, 1'b0, E_CLEAR, "min c1");
    cyc(1, 1'b0, 1'b0, E_ARM, "min c2");
    for (int k = 3; k <= 8; k++) cyc(1, 1'b0, 1'b0, E_STB, $sformatf("min run c%0d", k));
    cyc(1, 1'b0, 1'b1, E_DRAIN, "min drain c9");
    cyc(1, 1'b0, 1'b0, E_DRAIN, "min drain c10");
    cyc(1, 1'b0, 1'b0, E_OFF, "min off c11");

    // Asynchronous reset in the middle of DRAIN, between edges.
    for (int k = 1; k <= 10; k++)
      cyc(0, (k == 1), 1'b0, start_exp(k), $sformatf("pre rst c%0d", k));
    for (int k = 11; k <= 13; k++)
      cyc(0, 1'b0, (k == 11), E_DRAIN, $sformatf("pre rst drain c%0d", k));
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(E_OFF);
    e = exp_q.pop_front();
    chk("async reset", a_out, e);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++)
      cyc(0, (k == 1), 1'b0, start_exp(k), $sformatf("restart c%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
